// File: rtl/interrupt_dispatcher_pkg.sv
// rtl/interrupt_dispatcher_pkg.sv - shared constants and FSM encoding for the interrupt dispatcher
//
// Purpose : cause-code constants, core-side constants (cause register index,
//           return opcode, handler entry) and the dispatcher state encoding.
// Ports   : none (package).
package core_defs;

    // Cause codes delivered by the interruption trigger on intrpt_val
    localparam logic [5:0] CAUSE_SWAP     = 6'd0;
    localparam logic [5:0] CAUSE_QUANTUM  = 6'd1;
    localparam logic [5:0] CAUSE_IN       = 6'd2;
    localparam logic [5:0] CAUSE_OUT      = 6'd3;
    localparam logic [5:0] CAUSE_END      = 6'd4;
    localparam logic [5:0] CAUSE_UART_IN  = 6'd5;
    localparam logic [5:0] CAUSE_UART_OUT = 6'd6;

    // Core-side constants
    localparam logic [4:0]  CAUSE_REG     = 5'd28;
    localparam logic [5:0]  RETURN_OPCODE = 6'b100101;
    localparam logic [15:0] HANDLER_ADDR  = 16'h0000;

    // Dispatcher sequence states
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SAVE    = 3'd1,
        VECTOR  = 3'd2,
        SERVICE = 3'd3,
        RESTORE = 3'd4
    } state_t;

endpackage

// File: rtl/intrpt_pending_slot.sv
// rtl/intrpt_pending_slot.sv - one-deep pending interrupt register with saturating drop counter
//
// Purpose : holds at most one interrupt raised while the dispatcher is busy.
//           A push into an occupied slot is discarded and counted.
// Ports   : clk, reset_n         clock / synchronous active-low reset
//           push, push_cause     store request and its cause code
//           pop                  consume the held request (tail-chain)
//           pending_valid        slot occupied
//           pending_cause        held cause code
//           drop_count           saturating count of discarded requests
module intrpt_pending_slot #(
    parameter int CAUSE_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [CAUSE_WIDTH-1:0] push_cause,
    input  logic                   pop,
    output logic                   pending_valid,
    output logic [CAUSE_WIDTH-1:0] pending_cause,
    output logic [3:0]             drop_count
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending_valid <= 1'b0;
            pending_cause <= '0;
            drop_count    <= 4'd0;
        end else begin
            if (pop) begin
                pending_valid <= 1'b0;
            end
            // Occupancy is judged before this cycle's pop: a request that
            // arrives while the held one is being chained is still dropped.
            if (push) begin
                if (pending_valid) begin
                    if (drop_count != 4'hF) begin
                        drop_count <= drop_count + 4'd1;
                    end
                end else begin
                    pending_valid <= 1'b1;
                    pending_cause <= push_cause;
                end
            end
        end
    end

endmodule

// File: rtl/interrupt_dispatcher.sv
// rtl/interrupt_dispatcher.sv - turns accepted interrupts into the stall/save/vector/restore core sequence
//
// Purpose : accepts intrpt/intrpt_val from the trigger, stalls the core, writes
//           the cause code into the cause register, vectors to the OS handler,
//           keeps the core in the handler until the return opcode, then either
//           restores EPC or tail-chains a pending interrupt.
// Ports   : single_clk, reset_n          clock / synchronous active-low reset
//           intrpt, intrpt_val           interrupt request and cause code
//           opcode                       currently executing opcode
//           pc_current                   PC to resume at
//           stall                        freeze fetch/execute
//           pc_load, pc_load_val         one-cycle PC load strobe and target
//           reg_wr_en/addr/data          one-cycle cause register write
//           in_handler                   OS handler running
//           epc                          saved return PC
//           drop_count                   saturating count of discarded interrupts
module interrupt_dispatcher #(
    parameter int                        PC_WIDTH       = 16,
    parameter int                        DATA_WIDTH     = 32,
    parameter int                        DEFAULT_WIDTH  = 6,
    parameter int                        REG_ADDR_WIDTH = 5,
    parameter logic [REG_ADDR_WIDTH-1:0] CAUSE_REG      = core_defs::CAUSE_REG,
    parameter logic [PC_WIDTH-1:0]       HANDLER_ADDR   = core_defs::HANDLER_ADDR,
    parameter logic [DEFAULT_WIDTH-1:0]  RETURN_OPCODE  = core_defs::RETURN_OPCODE
) (
    input  logic                      single_clk,
    input  logic                      reset_n,
    input  logic                      intrpt,
    input  logic [DEFAULT_WIDTH-1:0]  intrpt_val,
    input  logic [DEFAULT_WIDTH-1:0]  opcode,
    input  logic [PC_WIDTH-1:0]       pc_current,
    output logic                      stall,
    output logic                      pc_load,
    output logic [PC_WIDTH-1:0]       pc_load_val,
    output logic                      reg_wr_en,
    output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr,
    output logic [DATA_WIDTH-1:0]     reg_wr_data,
    output logic                      in_handler,
    output logic [PC_WIDTH-1:0]       epc,
    output logic [3:0]                drop_count
);
    import core_defs::*;

    state_t                     state;
    state_t                     state_next;
    logic [DEFAULT_WIDTH-1:0]   cause;
    logic                       pending_valid;
    logic [DEFAULT_WIDTH-1:0]   pending_cause;

    logic                       is_idle;
    logic                       ret;
    logic                       direct_chain;
    logic                       slot_push;
    logic                       slot_pop;

    assign is_idle = (state == IDLE);
    assign ret     = (state == SERVICE) && (opcode == RETURN_OPCODE);

    // A return that coincides with a fresh request and an empty slot chains
    // the fresh request straight into SAVE; it never touches the slot.
    assign direct_chain = ret && intrpt && !pending_valid;
    assign slot_push    = intrpt && !is_idle && !direct_chain;
    assign slot_pop     = ret && pending_valid;

    intrpt_pending_slot #(
        .CAUSE_WIDTH (DEFAULT_WIDTH)
    ) u_pending_slot (
        .clk           (single_clk),
        .reset_n       (reset_n),
        .push          (slot_push),
        .push_cause    (intrpt_val),
        .pop           (slot_pop),
        .pending_valid (pending_valid),
        .pending_cause (pending_cause),
        .drop_count    (drop_count)
    );

    // State register
    always_ff @(posedge single_clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (intrpt) state_next = SAVE;
            SAVE:    state_next = VECTOR;
            VECTOR:  state_next = SERVICE;
            SERVICE: begin
                if (ret) begin
                    state_next = (pending_valid || intrpt) ? SAVE : RESTORE;
                end
            end
            RESTORE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Cause and EPC capture. EPC is only written on entry from IDLE so a
    // tail-chained handler still returns to the original interrupted PC.
    always_ff @(posedge single_clk) begin
        if (!reset_n) begin
            cause <= '0;
            epc   <= '0;
        end else if (is_idle && intrpt) begin
            cause <= intrpt_val;
            epc   <= pc_current;
        end else if (ret) begin
            if (pending_valid) begin
                cause <= pending_cause;
            end else if (intrpt) begin
                cause <= intrpt_val;
            end
        end
    end

    // Moore output decode
    always_comb begin
        stall       = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = '0;
        reg_wr_en   = 1'b0;
        reg_wr_addr = '0;
        reg_wr_data = '0;
        in_handler  = 1'b0;
        case (state)
            SAVE: begin
                stall       = 1'b1;
                reg_wr_en   = 1'b1;
                reg_wr_addr = CAUSE_REG;
                reg_wr_data = {{(DATA_WIDTH-DEFAULT_WIDTH){1'b0}}, cause};
            end
            VECTOR: begin
                stall       = 1'b1;
                pc_load     = 1'b1;
                pc_load_val = HANDLER_ADDR;
            end
            SERVICE: begin
                in_handler  = 1'b1;
            end
            RESTORE: begin
                stall       = 1'b1;
                pc_load     = 1'b1;
                pc_load_val = epc;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_interrupt_dispatcher.sv
// tb/tb_interrupt_dispatcher.sv - scoreboard bench for interrupt_dispatcher
module tb_interrupt_dispatcher;

    localparam logic [5:0] RET_OP = 6'b100101;

    logic        single_clk = 1'b0;
    logic        reset_n    = 1'b0;
    logic        intrpt     = 1'b0;
    logic [5:0]  intrpt_val = '0;
    logic [5:0]  opcode     = '0;
    logic [15:0] pc_current = '0;
    logic        stall;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic        reg_wr_en;
    logic [4:0]  reg_wr_addr;
    logic [31:0] reg_wr_data;
    logic        in_handler;
    logic [15:0] epc;
    logic [3:0]  drop_count;

    interrupt_dispatcher dut (
        .single_clk  (single_clk),
        .reset_n     (reset_n),
        .intrpt      (intrpt),
        .intrpt_val  (intrpt_val),
        .opcode      (opcode),
        .pc_current  (pc_current),
        .stall       (stall),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .in_handler  (in_handler),
        .epc         (epc),
        .drop_count  (drop_count)
    );

    always #5 single_clk = ~single_clk;

    typedef struct {
        logic        stall;
        logic        pc_load;
        logic [15:0] pc_load_val;
        logic        reg_wr_en;
        logic [4:0]  reg_wr_addr;
        logic [31:0] reg_wr_data;
        logic        in_handler;
        logic [15:0] epc;
        logic [3:0]  drop_count;
    } frame_t;

    frame_t exp_q[$];
    int     checks   = 0;
    int     failures = 0;

    // Reference model: a handler entry enqueues its fixed preamble frames,
    // a plain return enqueues the restore frame; with no scripted frame left
    // the core is either in the handler or idle.
    frame_t      script[$];
    logic [5:0]  m_pend[$];
    bit          handling = 0;
    int          cur_kind = 0;   // 0 idle, 1 scripted, 2 in handler
    logic [15:0] m_epc    = '0;
    int          m_drops  = 0;

    function automatic frame_t blank();
        frame_t f;
        f.stall = 0; f.pc_load = 0; f.pc_load_val = 0; f.reg_wr_en = 0;
        f.reg_wr_addr = 0; f.reg_wr_data = 0; f.in_handler = 0;
        f.epc = 0; f.drop_count = 0;
        return f;
    endfunction

    task automatic start_handler(input logic [5:0] c);
        frame_t f;
        f = blank();
        f.stall = 1; f.reg_wr_en = 1; f.reg_wr_addr = 5'd28; f.reg_wr_data = 32'(c);
        script.push_back(f);
        f = blank();
        f.stall = 1; f.pc_load = 1; f.pc_load_val = 16'h0000;
        script.push_back(f);
        handling = 1;
    endtask

    task automatic note_drop();
        if (m_drops < 15) m_drops++;
    endtask

    task automatic model_step(input logic rst, input logic ir, input logic [5:0] iv,
                              input logic [5:0] op, input logic [15:0] pc);
        frame_t f;
        bit     ret;
        if (!rst) begin
            script.delete(); m_pend.delete();
            handling = 0; cur_kind = 0; m_epc = 0; m_drops = 0;
            exp_q.push_back(blank());
            return;
        end
        ret = (cur_kind == 2) && (op == RET_OP);
        if (cur_kind == 0) begin
            if (ir) begin
                m_epc = pc;
                start_handler(iv);
            end
        end else if (ret) begin
            if (m_pend.size() > 0) begin
                start_handler(m_pend.pop_front());
                if (ir) note_drop();
            end else if (ir) begin
                start_handler(iv);
            end else begin
                f = blank();
                f.stall = 1; f.pc_load = 1; f.pc_load_val = m_epc;
                script.push_back(f);
                handling = 0;
            end
        end else if (ir) begin
            if (m_pend.size() == 0) m_pend.push_back(iv);
            else note_drop();
        end
        if (script.size() > 0) begin
            f = script.pop_front();
            cur_kind = 1;
        end else if (handling) begin
            f = blank();
            f.in_handler = 1;
            cur_kind = 2;
        end else begin
            f = blank();
            cur_kind = 0;
        end
        f.epc = m_epc;
        f.drop_count = 4'(m_drops);
        exp_q.push_back(f);
    endtask

    task automatic drive(input logic rst, input logic ir, input logic [5:0] iv,
                         input logic [5:0] op, input logic [15:0] pc);
        @(negedge single_clk);
        reset_n    = rst;
        intrpt     = ir;
        intrpt_val = iv;
        opcode     = op;
        pc_current = pc;
        model_step(rst, ir, iv, op, pc);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 6'd0, 6'd0, 16'h1234);
    endtask

    // Monitor: compares each presented output frame against the scoreboard
    always begin
        @(posedge single_clk);
        #2;
        if (exp_q.size() > 0) begin
            frame_t e;
            e = exp_q.pop_front();
            checks++;
            if (stall !== e.stall || pc_load !== e.pc_load || pc_load_val !== e.pc_load_val ||
                reg_wr_en !== e.reg_wr_en || reg_wr_addr !== e.reg_wr_addr ||
                reg_wr_data !== e.reg_wr_data || in_handler !== e.in_handler ||
                epc !== e.epc || drop_count !== e.drop_count) begin
                failures++;
                $display("FAIL frame t=%0t got stall=%b pcl=%b pcv=%h we=%b wa=%0d wd=%h ih=%b epc=%h drop=%0d expected stall=%b pcl=%b pcv=%h we=%b wa=%0d wd=%h ih=%b epc=%h drop=%0d",
                         $time, stall, pc_load, pc_load_val, reg_wr_en, reg_wr_addr, reg_wr_data,
                         in_handler, epc, drop_count, e.stall, e.pc_load, e.pc_load_val,
                         e.reg_wr_en, e.reg_wr_addr, e.reg_wr_data, e.in_handler, e.epc, e.drop_count);
            end
        end
    end

    initial begin
        // Reset state
        drive(0, 0, 6'd0, 6'd0, 16'h0);
        drive(0, 1, 6'd7, 6'd0, 16'h0);
        idle_cycles(2);

        // Basic entry with cause 2, return without pending
        drive(1, 1, 6'd2, 6'd0, 16'h0040);
        idle_cycles(4);
        drive(1, 0, 6'd0, RET_OP, 16'h5555);
        idle_cycles(2);

        // Tail-chain: cause 3 pends during SERVICE, then return
        drive(1, 1, 6'd2, 6'd0, 16'h0040);
        idle_cycles(3);
        drive(1, 1, 6'd3, 6'd0, 16'h0100);
        idle_cycles(1);
        drive(1, 0, 6'd0, RET_OP, 16'h0200);
        idle_cycles(3);
        drive(1, 0, 6'd0, RET_OP, 16'h0200);
        idle_cycles(2);

        // Three pulses during SERVICE: one pends, two dropped
        drive(0, 0, 6'd0, 6'd0, 16'h0);
        drive(1, 1, 6'd0, 6'd0, 16'h0080);
        idle_cycles(3);
        drive(1, 1, 6'd1, 6'd0, 16'h0);
        drive(1, 1, 6'd5, 6'd0, 16'h0);
        drive(1, 1, 6'd6, 6'd0, 16'h0);
        drive(1, 0, 6'd0, RET_OP, 16'h0);
        idle_cycles(3);

        // Return and cause 4 together with empty slot
        drive(1, 1, 6'd4, RET_OP, 16'h0);
        idle_cycles(3);

        // Return with slot full and concurrent request
        drive(1, 1, 6'd5, 6'd0, 16'h0);
        drive(1, 1, 6'd6, RET_OP, 16'h0);
        idle_cycles(3);

        // Saturate drop counter
        drive(1, 1, 6'd1, 6'd0, 16'h0);
        for (int i = 0; i < 18; i++) drive(1, 1, 6'(i), 6'd0, 16'h0);
        drive(1, 0, 6'd0, RET_OP, 16'h0);
        idle_cycles(3);
        drive(1, 0, 6'd0, RET_OP, 16'h0);
        idle_cycles(2);

        // Reset during VECTOR, then normal sequence
        drive(1, 1, 6'd6, 6'd0, 16'h0abc);
        idle_cycles(1);
        drive(0, 0, 6'd0, 6'd0, 16'h0);
        drive(1, 1, 6'd1, 6'd0, 16'h0def);
        idle_cycles(3);
        drive(1, 0, 6'd0, RET_OP, 16'h0);
        idle_cycles(2);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            logic       rst;
            logic       ir;
            logic [5:0] iv;
            logic [5:0] op;
            rst = ($urandom_range(0, 199) != 0);
            ir  = ($urandom_range(0, 99) < 15);
            iv  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 6));
            op  = ($urandom_range(0, 99) < 20) ? RET_OP : 6'($urandom_range(0, 63));
            drive(rst, ir, iv, op, 16'($urandom));
        end

        // Scoreboard must drain within a bounded number of cycles
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge single_clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
